// File: rtl/ic_scr_key_ctrl_pkg.sv
// Shared constants for the ICache scrambling-key refresh controller:
// key/nonce widths, boot key/nonce values and FSM state encodings.
package ic_scr_key_ctrl_pkg;

    localparam int unsigned SCRAMBLE_KEY_W   = 128;
    localparam int unsigned SCRAMBLE_NONCE_W = 64;

    localparam logic [SCRAMBLE_KEY_W-1:0]   IC_SCR_RST_KEY   = 128'h3ba7_1d44_9c2e_5f80_a6d1_0e73_c4b9_2f15;
    localparam logic [SCRAMBLE_NONCE_W-1:0] IC_SCR_RST_NONCE = 64'hf4a2_8b3c_61d0_97e5;

    typedef logic [1:0] ic_scr_key_state_e;

    localparam ic_scr_key_state_e ST_VALID   = 2'd0;
    localparam ic_scr_key_state_e ST_REQ     = 2'd1;
    localparam ic_scr_key_state_e ST_BACKOFF = 2'd2;
    localparam ic_scr_key_state_e ST_ERR     = 2'd3;

endpackage

// File: rtl/ic_scr_key_ctrl.sv
// ICache scrambling-key refresh controller. An ICache invalidate drops
// key_valid and fetches a fresh key/nonce from OTP over a req/ack handshake.
// Optional OTP latency bound with timeout/retry/error: macro IC_SCR_KEY_TIMEOUT_EN.
module ic_scr_key_ctrl
    import ic_scr_key_ctrl_pkg::*;
#(
    parameter int unsigned       KeyW          = SCRAMBLE_KEY_W,
    parameter int unsigned       NonceW        = SCRAMBLE_NONCE_W,
    parameter logic [KeyW-1:0]   RstKey        = IC_SCR_RST_KEY,
    parameter logic [NonceW-1:0] RstNonce      = IC_SCR_RST_NONCE,
    parameter int unsigned       TimeoutCycles = 64,
    parameter int unsigned       MaxRetries    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              icache_inval_i,
    output logic              key_valid_o,
    output logic [KeyW-1:0]   key_o,
    output logic [NonceW-1:0] nonce_o,
    output logic              otp_req_o,
    input  logic              otp_ack_i,
    input  logic [KeyW-1:0]   otp_key_i,
    input  logic [NonceW-1:0] otp_nonce_i,
    output logic              busy_o,
    output logic              key_err_o,
    output logic [7:0]        refresh_cnt_o
);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end
    if (MaxRetries < 1) begin : g_bad_retries
        $error("MaxRetries must be at least 1");
    end

    ic_scr_key_state_e state_q;
    logic              key_valid_q;
    logic              req_q;
    logic [7:0]        cnt_q;
    logic [KeyW-1:0]   key_q;
    logic [NonceW-1:0] nonce_q;
    logic              ack_accept;

`ifdef IC_SCR_KEY_TIMEOUT_EN
    localparam int TimerW = $clog2(TimeoutCycles);
    localparam int RetryW = $clog2(MaxRetries + 1);

    logic [TimerW-1:0] timer_q;
    logic [RetryW-1:0] retry_q;
    logic              err_q;
`endif

    // An ack only counts while a request is actually outstanding.
    assign ack_accept = req_q & otp_ack_i;

    // Refresh sequencing: request issue, completion, inval/ack collision and timeouts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_VALID;
            key_valid_q <= 1'b1;
            req_q       <= 1'b0;
            cnt_q       <= 8'd0;
`ifdef IC_SCR_KEY_TIMEOUT_EN
            timer_q     <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_VALID: begin
                    if (icache_inval_i) begin
                        state_q     <= ST_REQ;
                        key_valid_q <= 1'b0;
                        req_q       <= 1'b1;
`ifdef IC_SCR_KEY_TIMEOUT_EN
                        timer_q     <= '0;
                        retry_q     <= '0;
`endif
                    end
                end
                ST_REQ: begin
                    if (!req_q) begin
                        // One-cycle gap after an inval/ack collision; reissue.
                        req_q <= 1'b1;
`ifdef IC_SCR_KEY_TIMEOUT_EN
                        timer_q <= '0;
`endif
                    end else if (ack_accept) begin
                        req_q <= 1'b0;
`ifdef IC_SCR_KEY_TIMEOUT_EN
                        timer_q <= '0;
`endif
                        if (!icache_inval_i) begin
                            // Key just captured is stale if inval coincides; otherwise done.
                            state_q     <= ST_VALID;
                            key_valid_q <= 1'b1;
                            if (cnt_q != 8'hFF) begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
`ifdef IC_SCR_KEY_TIMEOUT_EN
                    end else if (timer_q == TimerW'(TimeoutCycles - 1)) begin
                        req_q   <= 1'b0;
                        timer_q <= '0;
                        if (retry_q == RetryW'(MaxRetries)) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_BACKOFF;
                            retry_q <= retry_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
`endif
                    end
                end
`ifdef IC_SCR_KEY_TIMEOUT_EN
                ST_BACKOFF: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                    timer_q <= '0;
                end
                ST_ERR: begin
                    if (icache_inval_i) begin
                        state_q <= ST_REQ;
                        err_q   <= 1'b0;
                        retry_q <= '0;
                        timer_q <= '0;
                        req_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_VALID;
                    key_valid_q <= 1'b1;
                    req_q       <= 1'b0;
                end
            endcase
        end
    end

    // Key/nonce hold the boot values until an accepted ack replaces them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q   <= RstKey;
            nonce_q <= RstNonce;
        end else if (ack_accept) begin
            key_q   <= otp_key_i;
            nonce_q <= otp_nonce_i;
        end
    end

    assign key_valid_o   = key_valid_q;
    assign key_o         = key_q;
    assign nonce_o       = nonce_q;
    assign otp_req_o     = req_q;
    assign busy_o        = (state_q != ST_VALID);
    assign refresh_cnt_o = cnt_q;
`ifdef IC_SCR_KEY_TIMEOUT_EN
    assign key_err_o     = err_q;
`else
    assign key_err_o     = 1'b0;
`endif

endmodule
